fill_batch_sequencer: RTL
=========================

FILL_BATCH_SEQUENCER -- requirements
Module: fill_batch_sequencer

Interface
REQ-001 Parameter TMO_CYCLES, default 1000: max Clk cycles in FILL without a pill before fault.
REQ-002 Parameter TOTAL_W, default 16: width of PillTotal.
REQ-003 Clk  in  1  system clock; all state changes on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 Start  in  1  level, sampled each cycle; begins a batch in IDLE, resumes from PAUSE.
REQ-006 Stop  in  1  level; emergency pause request.
REQ-007 PillPulse  in  1  one-cycle pill-detected strobe, already synchronous to Clk.
REQ-008 BottleIn  in  1  level; bottle present under the valve.
REQ-009 PillTarget  in  8  pills per bottle; sampled in LOAD only.
REQ-010 BottleTarget  in  8  bottles per batch; sampled in LOAD only.
REQ-011 Valve  out  1  1 = dispensing valve open.
REQ-012 BeltMotor  out  1  1 = conveyor running.
REQ-013 Busy  out  1  1 in every state except IDLE and FAULT.
REQ-014 Done  out  1  one-cycle pulse at batch completion.
REQ-015 Fault  out  1  level; 1 while in FAULT.
REQ-016 PillTotal  out  TOTAL_W  pills counted in the current batch.
REQ-017 BottleCount  out  8  bottles completed in the current batch.
REQ-018 StateOut  out  3  current state encoding, for debug.

Function
REQ-019 States: IDLE=0, LOAD=1, MOVE=2, FILL=3, EJECT=4, PAUSE=5, DONE=6, FAULT=7.
REQ-020 IDLE: Start=1 -> LOAD; clears PillTotal and BottleCount on exit.
REQ-021 LOAD (1 cycle): latch both targets; if either is 0 -> FAULT, else -> MOVE.
REQ-022 MOVE: BeltMotor=1; BottleIn=1 -> FILL, with per-bottle pill count cleared.
REQ-023 FILL: Valve=1, BeltMotor=0; each PillPulse increments the per-bottle count and PillTotal.
REQ-024 FILL exits to EJECT in the cycle after the per-bottle count reaches the latched PillTarget; Valve drops the same edge.
REQ-025 PillPulse outside FILL still increments PillTotal (overspill accounting), never the per-bottle count.
REQ-026 FILL: idle-cycle counter resets on every PillPulse; reaching TMO_CYCLES -> FAULT.
REQ-027 FILL: BottleIn falling before the target is reached -> FAULT.
REQ-028 EJECT: BeltMotor=1; BottleIn=0 -> BottleCount+1, then DONE if it equals BottleTarget, else MOVE.
REQ-029 DONE (1 cycle): Done=1 -> IDLE; PillTotal and BottleCount hold until the next LOAD.
REQ-030 Stop=1 in LOAD, MOVE, FILL or EJECT -> PAUSE next edge; the interrupted state and all counters are saved.
REQ-031 PAUSE: Valve=0, BeltMotor=0, timeout counter frozen; Start=1 with Stop=0 -> saved state.
REQ-032 Stop has priority over Start in the same cycle; Stop in IDLE, DONE or FAULT is ignored.
REQ-033 FAULT: Valve=0, BeltMotor=0; exit only via Rst.
REQ-034 PillTotal saturates at all-ones; BottleCount cannot wrap, because it stops at BottleTarget.
REQ-035 Valve, BeltMotor, Busy, Fault and StateOut are registered or pure state decodes, with no input-to-output combinational path.

Reset
REQ-036 Rst=1 at a clock edge -> IDLE, all counters 0, saved state IDLE.
REQ-037 Reset output values: Valve=0, BeltMotor=0, Busy=0, Done=0, Fault=0, StateOut=0.
REQ-038 Rst overrides Stop, Start and any in-progress fill, including mid-FILL with the valve open.

Structure
REQ-039 Shared package fill_pkg holds the state encoding, the TMO_CYCLES default, and TOTAL_W.
REQ-040 One sub-module, fill_timeout_counter (load/clear/enable/expire), instantiated once.
REQ-041 Expected size is 150-300 lines of RTL.

Verification
REQ-042 Normal batch: PillTarget=3, BottleTarget=2, Start, bottles and 3 pills per bottle -> PillTotal=6, BottleCount=2, one Done pulse, back in IDLE.
REQ-043 Zero target: PillTarget=0, Start -> LOAD then FAULT, Valve never 1, Fault held until Rst.
REQ-044 Pause/resume: Stop after pill 2 of 5 in FILL -> PAUSE, Valve=0; Start -> FILL, 3 more pills -> EJECT, PillTotal=5.
REQ-045 Timeout: TMO_CYCLES=20, FILL with no pills -> FAULT exactly 20 cycles after FILL entry.
REQ-046 Priority and reset: Stop and Start both high in FILL -> PAUSE; Rst mid-FILL -> IDLE next edge, all outputs 0.
REQ-047 Overspill: a PillPulse during MOVE -> PillTotal+1, per-bottle count unchanged.

Source files
------------

// File: rtl/fill_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : fill_pkg                                                      |
// | Purpose  : Shared state encoding and defaults for the fill sequencer.    |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package fill_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MOVE  = 3'd2,
    ST_FILL  = 3'd3,
    ST_EJECT = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAULT = 3'd7
  } fillState_t;

  localparam int c_TMO_CYCLES = 1000;
  localparam int c_TOTAL_W    = 16;

  // States from which an emergency Stop parks the machine in PAUSE.
  function automatic logic isPausable(input fillState_t s);
    return (s == ST_LOAD) || (s == ST_MOVE) || (s == ST_FILL) || (s == ST_EJECT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fill_timeout_counter.sv
// ---------------------------------------------------------------------------
// | Module   : fill_timeout_counter                                          |
// | Purpose  : Down-counting no-pill watchdog; expires after TMO_CYCLES.     |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module fill_timeout_counter
  import fill_pkg::*;
#(
  parameter int TMO_CYCLES = c_TMO_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expire
);

  localparam int c_CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(TMO_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_count;

  // Reload to TMO_CYCLES-1 so expiry lands on the TMO_CYCLES-th enabled cycle.
  always_ff @(posedge Clk) begin
    if (Rst || i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_RELOAD;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - c_ONE;
    end
  end

  assign o_expire = i_enable && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fill_batch_sequencer.sv
// ---------------------------------------------------------------------------
// | Module   : fill_batch_sequencer                                          |
// | Purpose  : Pill-bottle batch filler: belt, valve, counting, pause, fault.|
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module fill_batch_sequencer
  import fill_pkg::*;
#(
  parameter int TMO_CYCLES = c_TMO_CYCLES,
  parameter int TOTAL_W    = c_TOTAL_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic               Stop,
  input  logic               PillPulse,
  input  logic               BottleIn,
  input  logic [7:0]         PillTarget,
  input  logic [7:0]         BottleTarget,
  output logic               Valve,
  output logic               BeltMotor,
  output logic               Busy,
  output logic               Done,
  output logic               Fault,
  output logic [TOTAL_W-1:0] PillTotal,
  output logic [7:0]         BottleCount,
  output logic [2:0]         StateOut
);

  fillState_t         r_state;
  fillState_t         r_savedState;
  fillState_t         w_nextState;
  logic [7:0]         r_pillTarget;
  logic [7:0]         r_bottleTarget;
  logic [7:0]         r_bottlePills;
  logic [7:0]         r_bottleCount;
  logic [TOTAL_W-1:0] r_pillTotal;

  logic w_tmoClear;
  logic w_tmoLoad;
  logic w_tmoEnable;
  logic w_tmoExpire;
  logic w_lastBottle;
  logic w_bottleFull;
  logic w_enterFill;
  logic w_batchClear;

  assign w_lastBottle = ((r_bottleCount + 8'd1) == r_bottleTarget);
  assign w_bottleFull = (r_bottlePills == r_pillTarget);
  assign w_enterFill  = (r_state == ST_MOVE) && (w_nextState == ST_FILL);
  assign w_batchClear = (r_state == ST_IDLE) && Start;

  // A pill in the same cycle as expiry counts as activity, not a timeout.
  assign w_tmoClear  = (r_state == ST_IDLE);
  assign w_tmoLoad   = w_enterFill || ((r_state == ST_FILL) && PillPulse);
  assign w_tmoEnable = (r_state == ST_FILL);

  fill_timeout_counter #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_timeout (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_clear  (w_tmoClear),
    .i_load   (w_tmoLoad),
    .i_enable (w_tmoEnable),
    .o_expire (w_tmoExpire)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (isPausable(r_state) && Stop) begin
      w_nextState = ST_PAUSE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (Start) w_nextState = ST_LOAD;
        end
        ST_LOAD: begin
          if ((PillTarget == 8'd0) || (BottleTarget == 8'd0)) w_nextState = ST_FAULT;
          else                                                w_nextState = ST_MOVE;
        end
        ST_MOVE: begin
          if (BottleIn) w_nextState = ST_FILL;
        end
        ST_FILL: begin
          if (w_bottleFull)                    w_nextState = ST_EJECT;
          else if (!BottleIn)                  w_nextState = ST_FAULT;
          else if (w_tmoExpire && !PillPulse)  w_nextState = ST_FAULT;
        end
        ST_EJECT: begin
          if (!BottleIn) w_nextState = w_lastBottle ? ST_DONE : ST_MOVE;
        end
        ST_PAUSE: begin
          if (Start && !Stop) w_nextState = r_savedState;
        end
        ST_DONE:  w_nextState = ST_IDLE;
        ST_FAULT: w_nextState = ST_FAULT;
        default:  w_nextState = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_savedState   <= ST_IDLE;
      r_pillTarget   <= 8'd0;
      r_bottleTarget <= 8'd0;
      r_bottlePills  <= 8'd0;
      r_bottleCount  <= 8'd0;
      r_pillTotal    <= '0;
    end else begin
      if ((w_nextState == ST_PAUSE) && (r_state != ST_PAUSE)) begin
        r_savedState <= r_state;
      end

      if (r_state == ST_LOAD) begin
        r_pillTarget   <= PillTarget;
        r_bottleTarget <= BottleTarget;
      end

      // Pills seen outside FILL still count toward the batch total.
      if (w_batchClear) begin
        r_pillTotal   <= '0;
        r_bottleCount <= 8'd0;
      end else begin
        if (PillPulse && (r_pillTotal != '1)) begin
          r_pillTotal <= r_pillTotal + TOTAL_W'(1);
        end
        if ((r_state == ST_EJECT) && ((w_nextState == ST_MOVE) || (w_nextState == ST_DONE))) begin
          r_bottleCount <= r_bottleCount + 8'd1;
        end
      end

      if (w_enterFill) begin
        r_bottlePills <= 8'd0;
      end else if ((r_state == ST_FILL) && PillPulse && (r_bottlePills != 8'hFF)) begin
        r_bottlePills <= r_bottlePills + 8'd1;
      end
    end
  end

  assign Valve       = (r_state == ST_FILL);
  assign BeltMotor   = (r_state == ST_MOVE) || (r_state == ST_EJECT);
  assign Busy        = (r_state != ST_IDLE) && (r_state != ST_FAULT);
  assign Done        = (r_state == ST_DONE);
  assign Fault       = (r_state == ST_FAULT);
  assign StateOut    = r_state;
  assign PillTotal   = r_pillTotal;
  assign BottleCount = r_bottleCount;

endmodule

`default_nettype wire
